// File: rtl/bitwise_pkg.sv
// bitwise_pkg: shared op and FSM state encodings for the bitwise reduction unit.
package bitwise_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/bitwise_op.sv
// bitwise_op: combinational two-input gate, WIDTH-generic successor of the
// fixed 32-bit gate blocks. NOR folds as OR; the caller inverts once at the end.
module bitwise_op
  import bitwise_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  // Gate select; OR and NOR share the OR path.
  always_comb begin
    y = a | b;
    case (op)
      OP_AND:  y = a & b;
      OP_XOR:  y = a ^ b;
      default: y = a | b;
    endcase
  end

endmodule

// File: rtl/bitwise_accum.sv
// bitwise_accum: streaming AND/OR/XOR/NOR reduction of a valid/ready burst.
// Optional out_popcnt port when BITWISE_ACCUM_POPCNT_EN is defined.
module bitwise_accum
  import bitwise_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef BITWISE_ACCUM_POPCNT_EN
  output logic [CNT_W-1:0] out_count,
  output logic [$clog2(WIDTH+1)-1:0] out_popcnt
`else
  output logic [CNT_W-1:0] out_count
`endif
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_fold, acc_nxt, res;
  logic [1:0]       op_q, op_eff;
  logic [CNT_W-1:0] count, cnt_nxt;
  logic             beat, hold_entry;

  assign beat       = in_valid & in_ready;
  assign hold_entry = beat & in_last;
  assign out_valid  = (state == S_HOLD);

  // op is only honoured on the first beat; later beats use the latched copy
  assign op_eff  = (state == S_IDLE) ? op : op_q;
  assign acc_nxt = (state == S_IDLE) ? in_data : acc_fold;
  assign cnt_nxt = (state == S_IDLE) ? CNT_W'(1)
                 : ((&count) ? count : count + CNT_W'(1));
  assign res     = (op_eff == OP_NOR) ? ~acc_nxt : acc_nxt;

  bitwise_op #(.WIDTH(WIDTH)) u_op (
    .op (op_q),
    .a  (acc),
    .b  (in_data),
    .y  (acc_fold)
  );

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next state and input ready
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b1;
    case (state)
      S_IDLE:  if (beat) state_nxt = in_last ? S_HOLD : S_ACCUM;
      S_ACCUM: if (hold_entry) state_nxt = S_HOLD;
      S_HOLD: begin
        in_ready = 1'b0;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Accumulator, beat counter and result registers; result is captured
  // on the edge taking the last beat so it is stable throughout HOLD.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc       <= '0;
      op_q      <= OP_AND;
      count     <= '0;
      out_data  <= '0;
      out_count <= '0;
    end else if (beat) begin
      acc   <= acc_nxt;
      count <= cnt_nxt;
      if (state == S_IDLE) op_q <= op;
      if (in_last) begin
        out_data  <= res;
        out_count <= cnt_nxt;
      end
    end else if (state == S_HOLD && out_ready) begin
      acc   <= '0;
      count <= '0;
    end
  end

`ifdef BITWISE_ACCUM_POPCNT_EN
  logic [$clog2(WIDTH+1)-1:0] pc_nxt;

  // Ones count of the outgoing result
  always_comb begin
    pc_nxt = '0;
    for (int i = 0; i < WIDTH; i++)
      pc_nxt = pc_nxt + {{($clog2(WIDTH+1)-1){1'b0}}, res[i]};
  end

  // Popcount register, loaded alongside out_data
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)        out_popcnt <= '0;
    else if (hold_entry) out_popcnt <= pc_nxt;
  end
`endif

endmodule

// File: tb/tb_bitwise_accum.sv
// tb_bitwise_accum: scoreboard bench for bitwise_accum (WIDTH=32, CNT_W=8).
module tb_bitwise_accum;
  import bitwise_pkg::*;

  localparam int PC_W = $clog2(33);

  logic        clock = 1'b0, reset_n = 1'b0;
  logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [31:0] in_data = '0, out_data;
  logic [1:0]  op = OP_AND;
  logic [7:0]  out_count;
`ifdef BITWISE_ACCUM_POPCNT_EN
  logic [PC_W-1:0] out_popcnt;
`endif

  typedef struct packed { logic [31:0] data; logic [7:0] cnt; } exp_t;
  exp_t        sb[$];
  logic [31:0] burst[$];
  int checks = 0, errors = 0;
  int cyc = 0, first_acc = 0, last_acc = 0;

  bitwise_accum #(.WIDTH(32), .CNT_W(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef BITWISE_ACCUM_POPCNT_EN
    .out_count(out_count), .out_popcnt(out_popcnt)
`else
    .out_count(out_count)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard pop on every output handshake
  always @(negedge clock) begin
    exp_t e;
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) chk("spurious_out", {63'b0, out_valid}, 64'd0);
      else begin
        e = sb.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_count", out_count, e.cnt);
`ifdef BITWISE_ACCUM_POPCNT_EN
        chk("out_popcnt", out_popcnt, $countones(e.data));
`endif
      end
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic [1:0] o, input logic l);
    bit done = 0;
    in_valid = 1'b1; in_data = d; op = o; in_last = l;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clock);
      if (in_ready) begin
        @(posedge clock); #1;
        last_acc = cyc;
        done = 1;
      end
    end
    if (!done) chk("accept_timeout", {63'b0, in_ready}, 64'd1);
  endtask

  // Sends burst[]; first beat with o0, the rest with o1 (must be ignored)
  task automatic run_burst(input logic [1:0] o0, input logic [1:0] o1);
    exp_t e;
    int n = burst.size();
    e.data = burst[0];
    for (int i = 1; i < n; i++)
      case (o0)
        OP_AND:  e.data = e.data & burst[i];
        OP_XOR:  e.data = e.data ^ burst[i];
        default: e.data = e.data | burst[i];
      endcase
    if (o0 == OP_NOR) e.data = ~e.data;
    e.cnt = (n > 255) ? 8'd255 : 8'(n);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) sb.push_back(e);
      send_beat(burst[i], (i == 0) ? o0 : o1, i == n - 1);
      if (i == 0) first_acc = last_acc;
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("latency_valid", {63'b0, out_valid}, 64'd1);
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(posedge clock); #1;
      if (sb.size() == 0) done = 1;
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    int prev_last;
    // reset state
    repeat (2) @(negedge clock);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // OR, three beats
    out_ready = 1'b1;
    burst = '{32'h0000_0001, 32'h0000_0100, 32'h8000_0000};
    run_burst(OP_OR, OP_OR);
    wait_drain();

    // AND with op changed to XOR mid-burst
    burst = '{32'hFFFF_00FF, 32'h0F0F_FFFF};
    run_burst(OP_AND, OP_XOR);
    wait_drain();

    // NOR single beat
    burst = '{32'h0000_FFFF};
    run_burst(OP_NOR, OP_NOR);
    wait_drain();

    // XOR 300 beats, saturating count, consumer stalls 5 cycles
    out_ready = 1'b0;
    burst.delete();
    for (int i = 0; i < 300; i++) burst.push_back(32'h1);
    run_burst(OP_XOR, OP_XOR);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("stall_valid", {63'b0, out_valid}, 64'd1);
      chk("stall_data", out_data, 0);
      chk("stall_count", out_count, 255);
      chk("stall_in_ready", {63'b0, in_ready}, 64'd0);
    end
    @(posedge clock); #1;
    out_ready = 1'b1;
    wait_drain();
    chk("post_hold_in_ready", {63'b0, in_ready}, 64'd1);

    // Reset mid-burst discards it
    send_beat(32'h1, OP_OR, 1'b0);
    send_beat(32'h2, OP_OR, 1'b0);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_valid", {63'b0, out_valid}, 64'd0);
    chk("midrst_data", out_data, 0);
    chk("midrst_count", out_count, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    burst = '{32'hA5, 32'h5A};
    run_burst(OP_XOR, OP_XOR);
    wait_drain();

    // Back-to-back bursts, out_ready tied high
    for (int b = 0; b < 5; b++) begin
      int len = $urandom_range(1, 4);
      logic [1:0] o = 2'($urandom_range(0, 3));
      burst.delete();
      for (int i = 0; i < len; i++) burst.push_back($urandom);
      run_burst(o, 2'($urandom_range(0, 3)));
      if (b > 0) chk("b2b_gap", first_acc - prev_last, 2);
      prev_last = last_acc;
    end
    wait_drain();
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitwise_accum.md
Name: bitwise_accum

Overview:
- Parametrised, streaming bitwise reduction unit; successor to the fixed 32-bit two-input gate blocks.
- Folds a burst of WIDTH-bit operands into one result using AND, OR, XOR or NOR, selected per burst.
- Valid/ready on both sides.
- Sits between the register-file/datapath and consumers needing mask merges, e.g. plotter pen/axis enable masks and status flag collection.

Parameters:
- WIDTH, 32: operand and result width in bits, 1 or more.
- CNT_W, 8: width of the beat counter; saturates at 2^CNT_W-1.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit accepts a beat.
- in_data  in  WIDTH  operand.
- in_last  in  1  final beat of the burst.
- op  in  2  operation: 00 AND, 01 OR, 10 XOR, 11 NOR. Sampled on the first beat only.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  reduced result.
- out_count  out  CNT_W  number of beats in the burst, saturating.

Behaviour:
- One clock, asynchronous active-low reset.
- Transfer occurs when valid and ready are both high on a rising clock edge.
- States: IDLE, ACCUM, HOLD. Reset state is IDLE.
- Reset values: acc=0, op_q=00, count=0, out_valid=0, out_data=0, out_count=0.
- in_ready is 1 in IDLE and ACCUM, and 0 in HOLD. It is combinational from state.
- While reset_n is low, no transfer takes effect.
- IDLE, on a beat: acc<=in_data; op_q<=op; count<=1. Next state is HOLD if in_last is high, otherwise ACCUM.
- ACCUM, on a beat: acc<=acc (op_q) in_data; count<=count+1, saturating at all-ones. Next state is HOLD if in_last is high.
- NOR is accumulated as OR; inversion is applied once at the output (out_data=~acc). NOR is therefore the complement of the OR of all beats, not a chained NOR.
- The op input is ignored after the first beat; changing it mid-burst has no effect.
- HOLD: out_valid=1; out_data and out_count are stable.
- When out_ready is seen in HOLD: out_valid falls on the next edge, state returns to IDLE, acc and count clear.
- Latency: out_valid rises exactly 1 cycle after the edge that accepted the last beat.
- Throughput: 1 beat per cycle within a burst. There is at least 1 idle input cycle per burst while in HOLD.
- A single-beat burst (in_last on the first beat) goes straight to HOLD. The result is in_data for AND/OR/XOR and ~in_data for NOR.
- out_ready held high before out_valid: the result is still presented for exactly 1 cycle.
- Reset asserted mid-burst or in HOLD: the burst is discarded, outputs clear immediately, state becomes IDLE. No partial result is ever emitted.
- in_valid low during ACCUM: state and acc hold; no timeout.

Optional Feature:
- Macro: BITWISE_ACCUM_POPCNT_EN.
- With the macro defined:
  - Extra output port out_popcnt  out  $clog2(WIDTH+1), equal to the number of ones in out_data.
  - Registered on entry to HOLD, so it is valid with out_valid.
  - Resets to 0.
- Without the macro: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package bitwise_pkg:
  - op encodings OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NOR=2'b11;
  - state encodings S_IDLE, S_ACCUM, S_HOLD.
- Sub-module bitwise_op (WIDTH parameter): combinational two-input AND/OR/XOR selected by op; it generalises the existing 32-bit gate blocks.
- bitwise_accum instantiates one bitwise_op for acc versus in_data.

Test Plan:
- OR, 3 beats 0x0000_0001, 0x0000_0100, 0x8000_0000 (last) -> out_data=0x8000_0101, out_count=3, out_valid 1 cycle after the last beat.
- AND, 2 beats 0xFFFF_00FF, 0x0F0F_FFFF; op switched to XOR on beat 2 -> out_data=0x0F0F_00FF (AND kept), out_count=2.
- NOR, single beat 0x0000_FFFF with last -> out_data=0xFFFF_0000, out_count=1; with popcount enabled, out_popcnt=16.
- XOR, 300 beats of 0x1 with out_ready held low for 5 cycles in HOLD -> out_data=0x0 and out_count=255 (saturated) stay stable; in_ready=0 until out_ready is taken.
- Reset asserted after beat 2 of an OR burst, then a fresh XOR burst 0xA5, 0x5A -> no output from the first burst; second result=0xFF, out_count=2.
- Back-to-back bursts with out_ready tied high -> each result valid exactly 1 cycle; the next burst's first beat is accepted on the cycle after the HOLD exit.
